// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized RX_PIN, 8N1 deframing (LSB first), one-entry holding register.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int unsigned sysfreq  = 50000000,
    parameter int unsigned baudrate = 115200
) (
    input  logic       SYSCLK,
    input  logic       RSTN,
    input  logic       RX_PIN,
    output logic [7:0] DATA,
    output logic       DATA_READY,
    input  logic       READ,
    output logic       BUSY_FLAG,
    output logic       ERROR_FLAG,
    output logic       OVERRUN_FLAG,
    output logic       PARITY_ERR
);

    localparam int unsigned CNT_W         = 10;
    localparam int unsigned COUNTER_LIMIT = sysfreq / baudrate;
    localparam int unsigned HALF_LIMIT    = COUNTER_LIMIT / 2;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(COUNTER_LIMIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_LIMIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
    } state_t;
`endif

    state_t           state;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
`ifdef UART_RX_PARITY_EN
    logic             par_bad;
    logic             parity_err_q;
`endif

    // Two-flop synchronizer; idle-high reset value so a low line after reset reads as a start edge.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_PIN;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM with holding register; frame events below override the READ clears.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            DATA         <= '0;
            DATA_READY   <= 1'b0;
            BUSY_FLAG    <= 1'b0;
            ERROR_FLAG   <= 1'b0;
            OVERRUN_FLAG <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            if (READ) begin
                DATA_READY   <= 1'b0;
                ERROR_FLAG   <= 1'b0;
                OVERRUN_FLAG <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end
            cnt <= cnt + CNT_W'(1);
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state     <= S_START;
                        BUSY_FLAG <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == HALF_END) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state     <= S_IDLE;
                            BUSY_FLAG <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        par_bad <= (^shift) ^ rx_s;
                        state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        if (rx_s) begin
                            DATA       <= shift;
                            DATA_READY <= 1'b1;
                            if (DATA_READY && !READ) begin
                                OVERRUN_FLAG <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err_q <= 1'b1;
                            end
`endif
                            state     <= S_IDLE;
                            BUSY_FLAG <= 1'b0;
                        end else begin
                            ERROR_FLAG <= 1'b1;
                            state      <= S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    // Hold off until the line returns high so a break does not produce frames.
                    cnt <= '0;
                    if (rx_s) begin
                        state     <= S_IDLE;
                        BUSY_FLAG <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    BUSY_FLAG <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign PARITY_ERR = parity_err_q;
`else
    assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: latency, glitch, framing, overrun, reset and loopback-style frames.
module tb_uart_rx;

    localparam int BIT = 434;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + 217 + 10 * 434 + 1;
`else
    localparam int LAT = 2 + 217 + 9 * 434 + 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       read;
    logic [7:0] data;
    logic       data_ready;
    logic       busy;
    logic       err;
    logic       ovr;
    logic       par_err;

    int total = 0;
    int bad   = 0;

    uart_rx dut (
        .SYSCLK      (clk),
        .RSTN        (rst_n),
        .RX_PIN      (rx),
        .DATA        (data),
        .DATA_READY  (data_ready),
        .READ        (read),
        .BUSY_FLAG   (busy),
        .ERROR_FLAG  (err),
        .OVERRUN_FLAG(ovr),
        .PARITY_ERR  (par_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Caller must be at a negedge; the start bit begins immediately.
    task automatic send_byte(input logic [7:0] b, input logic stop_val, input logic bad_par);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ bad_par;
        repeat (BIT) @(negedge clk);
`else
        if (bad_par) rx = 1'b1;
`endif
        rx = stop_val;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic read_pulse();
        @(negedge clk);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    initial begin
        logic [7:0] lb [3];
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h81;

        rst_n = 1'b0;
        rx    = 1'b1;
        read  = 1'b0;
        idle(5);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_ready", 32'(data_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_ovr", 32'(ovr), 32'h0);
        chk("rst_par", 32'(par_err), 32'h0);
        rst_n = 1'b1;
        idle(10);

        // 0xA5 with exact latency check
        fork
            send_byte(8'hA5, 1'b1, 1'b0);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1;
                chk("a5_ready_early", 32'(data_ready), 32'h0);
                chk("a5_busy_mid", 32'(busy), 32'h1);
                @(posedge clk);
                #1;
                chk("a5_ready", 32'(data_ready), 32'h1);
                chk("a5_data", 32'(data), 32'hA5);
                @(posedge clk);
                #1;
                chk("a5_busy_low", 32'(busy), 32'h0);
                chk("a5_err", 32'(err), 32'h0);
                chk("a5_ovr", 32'(ovr), 32'h0);
            end
        join
        read_pulse();
        chk("a5_read_clr", 32'(data_ready), 32'h0);

        // 100-cycle glitch on idle line
        idle(10);
        rx = 1'b0;
        fork
            begin
                repeat (100) @(negedge clk);
                rx = 1'b1;
            end
            begin
                repeat (50) @(posedge clk);
                #1;
                chk("glitch_busy_hi", 32'(busy), 32'h1);
            end
        join
        idle(300);
        chk("glitch_busy_lo", 32'(busy), 32'h0);
        chk("glitch_ready", 32'(data_ready), 32'h0);
        chk("glitch_err", 32'(err), 32'h0);

        // Framing error followed by a break
        send_byte(8'h3C, 1'b0, 1'b0);
        idle(2000);
        chk("ferr_err", 32'(err), 32'h1);
        chk("ferr_ready", 32'(data_ready), 32'h0);
        chk("ferr_busy_wait", 32'(busy), 32'h1);
        rx = 1'b1;
        idle(20);
        chk("ferr_busy_rel", 32'(busy), 32'h0);
        send_byte(8'h55, 1'b1, 1'b0);
        idle(5);
        chk("after_ferr_data", 32'(data), 32'h55);
        chk("after_ferr_ready", 32'(data_ready), 32'h1);
        chk("after_ferr_err_sticky", 32'(err), 32'h1);
        read_pulse();
        chk("ferr_read_err", 32'(err), 32'h0);
        chk("ferr_read_ready", 32'(data_ready), 32'h0);

        // Back-to-back frames without READ -> overrun
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        idle(5);
        chk("ovr_data", 32'(data), 32'h22);
        chk("ovr_ready", 32'(data_ready), 32'h1);
        chk("ovr_flag", 32'(ovr), 32'h1);
        read_pulse();
        chk("ovr_clr_ready", 32'(data_ready), 32'h0);
        chk("ovr_clr_flag", 32'(ovr), 32'h0);
        chk("ovr_clr_err", 32'(err), 32'h0);

        // READ coincident with completion of the second byte
        send_byte(8'h11, 1'b1, 1'b0);
        fork
            send_byte(8'h22, 1'b1, 1'b0);
            begin
                repeat (LAT - 1) @(posedge clk);
                @(negedge clk);
                read = 1'b1;
                @(posedge clk);
                #1;
                chk("coin_data", 32'(data), 32'h22);
                chk("coin_ready", 32'(data_ready), 32'h1);
                chk("coin_ovr", 32'(ovr), 32'h0);
                @(negedge clk);
                read = 1'b0;
            end
        join
        read_pulse();

        // Reset in the middle of data bit 4 of 0xF0
        fork
            send_byte(8'hF0, 1'b1, 1'b0);
            begin
                repeat (220 + 4 * 434 + 200) @(posedge clk);
                #1;
                rst_n = 1'b0;
                #1;
                chk("mid_rst_data", 32'(data), 32'h0);
                chk("mid_rst_ready", 32'(data_ready), 32'h0);
                chk("mid_rst_busy", 32'(busy), 32'h0);
                chk("mid_rst_err", 32'(err), 32'h0);
            end
        join
        rst_n = 1'b1;
        idle(10);
        send_byte(8'h0F, 1'b1, 1'b0);
        idle(5);
        chk("post_rst_data", 32'(data), 32'h0F);
        chk("post_rst_ready", 32'(data_ready), 32'h1);
        read_pulse();

        // Transmitter-style byte sequence
        for (int i = 0; i < 3; i++) begin
            send_byte(lb[i], 1'b1, 1'b0);
            idle(5);
            chk("lb_data", 32'(data), 32'(lb[i]));
            chk("lb_ready", 32'(data_ready), 32'h1);
            chk("lb_par", 32'(par_err), 32'h0);
            chk("lb_ovr", 32'(ovr), 32'h0);
            read_pulse();
        end

`ifdef UART_RX_PARITY_EN
        send_byte(8'h81, 1'b1, 1'b1);
        idle(5);
        chk("par_bad_flag", 32'(par_err), 32'h1);
        chk("par_bad_data", 32'(data), 32'h81);
        chk("par_bad_ready", 32'(data_ready), 32'h1);
        read_pulse();
        chk("par_clr", 32'(par_err), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
